supernova_bpu_gshare: RTL

Second-generation fetch-stage branch predictor. It combines a parametrised direct-mapped BTB (partial tags and branch-type bits) with a gshare PHT of 2-bit counters indexed by PC XOR speculative global history. It also has a circular return address stack and a checkpointed GHR with mispredict recovery. Predictions are registered with 1-cycle latency, and an init sequencer clears all tables after reset.

---
 rtl/supernova_bpu_gshare.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/supernova_bpu_gshare.sv
// Fetch-stage predictor: direct-mapped BTB, gshare PHT, circular RAS, checkpointed GHR.
// Optional performance counters are built when SUPERNOVA_BPU_PERF_EN is defined.
module supernova_bpu_gshare #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned BTB_ENTRIES  = 1024,
    parameter int unsigned BTB_TAG_BITS = 16,
    parameter int unsigned PHT_ENTRIES  = 4096,
    parameter int unsigned GHR_BITS     = 12,
    parameter int unsigned RAS_DEPTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                req_valid,
    input  logic [XLEN-1:0]     req_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_taken,
    input  logic [1:0]          upd_type,
    input  logic                upd_mispredict,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic [31:0]         perf_lookups,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_mispredicts
);

    localparam int unsigned BtbIdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned RasPtrW = $clog2(RAS_DEPTH);
    localparam int unsigned InitLen = (BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES;
    localparam int unsigned InitW   = $clog2(InitLen);
    localparam int unsigned TagLsb  = 2 + BtbIdxW;

    localparam logic [1:0] TypeCond = 2'b00;
    localparam logic [1:0] TypeJump = 2'b01;
    localparam logic [1:0] TypeCall = 2'b10;
    localparam logic [1:0] TypeRet  = 2'b11;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [InitW-1:0]   init_cnt_q, init_cnt_d;

    logic                    btb_valid_q  [BTB_ENTRIES];
    logic [BTB_TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]         btb_target_q [BTB_ENTRIES];
    logic [1:0]              btb_type_q   [BTB_ENTRIES];
    logic [1:0]              pht_q        [PHT_ENTRIES];
    logic [XLEN-1:0]         ras_q        [RAS_DEPTH];

    logic [RasPtrW-1:0]  ras_ptr_q, ras_ptr_d;
    logic [RasPtrW:0]    ras_cnt_q, ras_cnt_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]     pred_target_q, pred_target_d;
    logic [GHR_BITS-1:0] pred_ghr_q, pred_ghr_d;

    logic                    run, lookup_fire, upd_fire;
    logic [BtbIdxW-1:0]      req_idx, upd_idx;
    logic [BTB_TAG_BITS-1:0] req_tag, upd_tag;
    logic [GHR_BITS-1:0]     req_pht_idx, upd_pht_idx;
    logic                    req_hit, lookup_taken;
    logic [XLEN-1:0]         lookup_target, ras_top;
    logic [1:0]              pht_cur, pht_nxt;
    logic                    btb_we, pht_we, ras_we;

    assign run         = (state_q == StRun);
    assign lookup_fire = run && req_valid;
    assign upd_fire    = run && upd_valid;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == InitW'(InitLen - 1)) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Lookup reads table state before this cycle's update lands (read-before-write).
    assign req_idx     = req_pc[2 +: BtbIdxW];
    assign req_tag     = req_pc[TagLsb +: BTB_TAG_BITS];
    assign req_pht_idx = req_pc[2 +: GHR_BITS] ^ ghr_q;
    assign req_hit     = btb_valid_q[req_idx] && (btb_tag_q[req_idx] == req_tag);
    assign ras_top     = ras_q[RasPtrW'(ras_ptr_q - 1'b1)];

    always_comb begin
        lookup_taken  = 1'b0;
        lookup_target = req_pc + XLEN'(4);
        if (req_hit) begin
            case (btb_type_q[req_idx])
                TypeCond: begin
                    lookup_taken = pht_q[req_pht_idx][1];
                    if (lookup_taken) lookup_target = btb_target_q[req_idx];
                end
                TypeJump, TypeCall: begin
                    lookup_taken  = 1'b1;
                    lookup_target = btb_target_q[req_idx];
                end
                default: begin
                    lookup_taken  = 1'b1;
                    lookup_target = (ras_cnt_q != '0) ? ras_top : btb_target_q[req_idx];
                end
            endcase
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (lookup_fire && req_hit && (btb_type_q[req_idx] == TypeCond)) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], lookup_taken};
        end
        if (upd_fire && upd_mispredict) begin
            ghr_d = (upd_type == TypeCond) ? {upd_ghr[GHR_BITS-2:0], upd_taken} : upd_ghr;
        end
    end

    always_comb begin
        pred_valid_d  = lookup_fire;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pred_ghr_d    = pred_ghr_q;
        if (lookup_fire) begin
            pred_taken_d  = lookup_taken;
            pred_target_d = lookup_target;
            pred_ghr_d    = ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            ghr_q         <= ghr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_ghr_q    <= pred_ghr_d;
        end
    end

    assign upd_idx     = upd_pc[2 +: BtbIdxW];
    assign upd_tag     = upd_pc[TagLsb +: BTB_TAG_BITS];
    assign upd_pht_idx = upd_pc[2 +: GHR_BITS] ^ upd_ghr;
    assign pht_cur     = pht_q[upd_pht_idx];
    assign btb_we      = upd_fire && (upd_taken || (upd_type != TypeCond));
    assign pht_we      = upd_fire && (upd_type == TypeCond);
    assign ras_we      = upd_fire && (upd_type == TypeCall);

    always_comb begin
        pht_nxt = pht_cur;
        if (upd_taken && (pht_cur != 2'b11)) pht_nxt = pht_cur + 2'b01;
        if (!upd_taken && (pht_cur != 2'b00)) pht_nxt = pht_cur - 2'b01;
    end

    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            btb_valid_q[BtbIdxW'(init_cnt_q)] <= 1'b0;
            pht_q[GHR_BITS'(init_cnt_q)]      <= 2'b01;
        end else begin
            if (btb_we) begin
                btb_valid_q[upd_idx]  <= 1'b1;
                btb_tag_q[upd_idx]    <= upd_tag;
                btb_target_q[upd_idx] <= upd_target;
                btb_type_q[upd_idx]   <= upd_type;
            end
            if (pht_we) pht_q[upd_pht_idx] <= pht_nxt;
        end
        if (ras_we) ras_q[ras_ptr_q] <= upd_pc + XLEN'(4);
    end

    // A full stack keeps wrapping the pointer, so the oldest entry is overwritten.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_we) begin
            ras_ptr_d = ras_ptr_q + 1'b1;
            if (ras_cnt_q != (RasPtrW + 1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
        end else if (upd_fire && (upd_type == TypeRet) && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_ptr_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

`ifdef SUPERNOVA_BPU_PERF_EN
    logic [31:0] perf_lookups_q, perf_hits_q, perf_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups_q <= '0;
            perf_hits_q    <= '0;
            perf_mis_q     <= '0;
        end else begin
            if (lookup_fire) perf_lookups_q <= perf_lookups_q + 32'd1;
            if (lookup_fire && req_hit) perf_hits_q <= perf_hits_q + 32'd1;
            if (upd_fire && upd_mispredict) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign perf_lookups     = perf_lookups_q;
    assign perf_hits        = perf_hits_q;
    assign perf_mispredicts = perf_mis_q;
`else
    assign perf_lookups     = 32'd0;
    assign perf_hits        = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

    assign ready       = run;
    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;
    assign pred_ghr    = pred_ghr_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[1:0], req_pc[XLEN-1:TagLsb+BTB_TAG_BITS],
                              upd_pc[1:0], upd_pc[XLEN-1:TagLsb+BTB_TAG_BITS]};

endmodule
